// File: rtl/booth_op_sequencer.sv
// Operand/result sequencer around the 8-bit radix-4 Booth multiplier core.
// Restarts the core, loads it byte-serially, waits for stop (with timeout) and returns the product.
//
// state | meaning
// IDLE  | ready for an operand pair, core held in reset
// CRST  | one-cycle core reset pulse
// LOADQ | start pulse, multiplier byte on inbus
// LOADM | multiplicand byte on inbus
// WAIT  | waiting for core stop or timeout
// DONE  | result held until consumer accepts
module booth_op_sequencer #(
  parameter int TIMEOUT_CYCLES = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic        core_rst,
  output logic        core_start,
  output logic [7:0]  core_inbus,
  input  logic [15:0] core_outbus,
  input  logic        core_stop,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_prod,
  output logic        out_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CRST, S_LOADQ, S_LOADM, S_WAIT, S_DONE
  } state_t;

  state_t r_state, w_next;

  logic [7:0]    r_a, r_b, w_a, w_b;
  logic [CW-1:0] r_cnt, w_cnt;
  logic          r_core_rst, r_core_start, r_out_valid, r_out_err;
  logic [7:0]    r_inbus;
  logic [15:0]   r_prod, w_prod;
  logic          w_err, w_core_rst, w_core_start, w_out_valid;
  logic [7:0]    w_inbus;

  always_comb begin
    w_next = r_state;
    w_a    = r_a;
    w_b    = r_b;
    w_cnt  = r_cnt;
    w_prod = r_prod;
    w_err  = r_out_err;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_a    = in_a;
          w_b    = in_b;
          w_next = S_CRST;
        end
      end
      S_CRST:  w_next = S_LOADQ;
      S_LOADQ: w_next = S_LOADM;
      S_LOADM: begin
        w_cnt  = '0;
        w_next = S_WAIT;
      end
      S_WAIT: begin
        w_cnt = r_cnt + 1'b1;
        // stop is checked first so a result on the last cycle is not lost
        if (core_stop) begin
          w_prod = core_outbus;
          w_err  = 1'b0;
          w_next = S_DONE;
        end else if (r_cnt == LAST) begin
          w_prod = '0;
          w_err  = 1'b1;
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase

    // registered outputs are decoded from the state being entered
    w_core_rst   = !(w_next == S_IDLE || w_next == S_CRST);
    w_core_start = (w_next == S_LOADQ);
    w_out_valid  = (w_next == S_DONE);
    w_inbus      = 8'h00;
    if (w_next == S_LOADQ) w_inbus = r_b;
    if (w_next == S_LOADM) w_inbus = r_a;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_cnt        <= '0;
      r_prod       <= '0;
      r_out_err    <= 1'b0;
      r_out_valid  <= 1'b0;
      r_core_rst   <= 1'b0;
      r_core_start <= 1'b0;
      r_inbus      <= '0;
    end else begin
      r_state      <= w_next;
      r_a          <= w_a;
      r_b          <= w_b;
      r_cnt        <= w_cnt;
      r_prod       <= w_prod;
      r_out_err    <= w_err;
      r_out_valid  <= w_out_valid;
      r_core_rst   <= w_core_rst;
      r_core_start <= w_core_start;
      r_inbus      <= w_inbus;
    end
  end

  assign in_ready   = (r_state == S_IDLE);
  assign core_rst   = r_core_rst;
  assign core_start = r_core_start;
  assign core_inbus = r_inbus;
  assign out_valid  = r_out_valid;
  assign out_prod   = r_prod;
  assign out_err    = r_out_err;

endmodule

// File: tb/tb_booth_op_sequencer.sv
// Directed bench for booth_op_sequencer with a behavioural byte-load core model.
module tb_booth_op_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = 8'h00;
  logic [7:0]  in_b = 8'h00;
  logic        core_rst;
  logic        core_start;
  logic [7:0]  core_inbus;
  logic [15:0] core_outbus = 16'h0000;
  logic        core_stop = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_prod;
  logic        out_err;

  int total = 0;
  int bad   = 0;
  int stop_dly = 20;

  booth_op_sequencer #(.TIMEOUT_CYCLES(63)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .core_rst(core_rst), .core_start(core_start), .core_inbus(core_inbus),
    .core_outbus(core_outbus), .core_stop(core_stop),
    .out_valid(out_valid), .out_ready(out_ready), .out_prod(out_prod), .out_err(out_err)
  );

  always #5 clk = ~clk;

  // core model: latch Q on start, M on the next cycle, raise stop stop_dly cycles after M
  logic signed [7:0] m_q = 8'sd0, m_m = 8'sd0;
  int m_phase = 0;
  int m_cnt = 0;
  always @(posedge clk) begin
    if (core_rst !== 1'b1) begin
      m_phase     <= 0;
      m_cnt       <= 0;
      core_stop   <= 1'b0;
      core_outbus <= 16'hA5A5;
    end else begin
      case (m_phase)
        0: if (core_start) begin m_q <= core_inbus; m_phase <= 1; end
        1: begin m_m <= core_inbus; m_phase <= 2; m_cnt <= 0; end
        2: begin
          if (m_cnt == stop_dly - 1) begin
            core_stop   <= 1'b1;
            core_outbus <= m_m * m_q;
            m_phase     <= 3;
          end else m_cnt <= m_cnt + 1;
        end
        default: ;
      endcase
    end
  end

  task tick;
    @(posedge clk);
    #1;
  endtask

  task send(input logic [7:0] a, input logic [7:0] b);
    int g;
    g = 0;
    while (!in_ready && g < 200) begin tick; g++; end
    in_a = a; in_b = b; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
  endtask

  task wait_valid(input int limit, output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < limit) begin tick; n++; end
  endtask

  task test_reset;
    rst = 1'b0; in_valid = 1'b1; in_a = 8'h11; in_b = 8'h22;
    tick; tick;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    total++; if (out_prod !== 16'h0000) begin bad++; $display("FAIL rst_out_prod got=%h want=0000", out_prod); end
    total++; if (out_err !== 1'b0) begin bad++; $display("FAIL rst_out_err got=%b want=0", out_err); end
    total++; if (core_rst !== 1'b0) begin bad++; $display("FAIL rst_core_rst got=%b want=0", core_rst); end
    total++; if (core_start !== 1'b0) begin bad++; $display("FAIL rst_core_start got=%b want=0", core_start); end
    total++; if (core_inbus !== 8'h00) begin bad++; $display("FAIL rst_core_inbus got=%h want=00", core_inbus); end
    in_valid = 1'b0; rst = 1'b1;
    tick;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_idle_after got=%b want=1", in_ready); end
  endtask

  task test_basic;
    int n;
    out_ready = 1'b1; stop_dly = 20;
    send(8'd3, 8'd5);
    total++; if ({in_ready, core_rst, core_start} !== 3'b000) begin bad++; $display("FAIL basic_crst got=%b want=000", {in_ready, core_rst, core_start}); end
    tick;
    total++; if ({core_rst, core_start, core_inbus} !== {2'b11, 8'h05}) begin bad++; $display("FAIL basic_loadq got=%b_%h want=11_05", {core_rst, core_start}, core_inbus); end
    tick;
    total++; if ({core_rst, core_start, core_inbus} !== {2'b10, 8'h03}) begin bad++; $display("FAIL basic_loadm got=%b_%h want=10_03", {core_rst, core_start}, core_inbus); end
    tick;
    total++; if ({core_rst, core_inbus, out_valid} !== {1'b1, 8'h00, 1'b0}) begin bad++; $display("FAIL basic_wait got=%b_%h_%b want=1_00_0", core_rst, core_inbus, out_valid); end
    wait_valid(100, n);
    total++; if (n !== 21) begin bad++; $display("FAIL basic_latency got=%0d want=21", n); end
    total++; if ({out_valid, out_prod, out_err} !== {1'b1, 16'h000F, 1'b0}) begin bad++; $display("FAIL basic_result got=%b_%h_%b want=1_000f_0", out_valid, out_prod, out_err); end
    tick;
    total++; if ({out_valid, in_ready, core_rst} !== 3'b010) begin bad++; $display("FAIL basic_pulse got=%b want=010", {out_valid, in_ready, core_rst}); end
  endtask

  task test_signed;
    logic [7:0]  ta [4];
    logic [7:0]  tb_ [4];
    logic [15:0] te [4];
    int n;
    ta  = '{8'hFD, 8'h80, 8'h7F, 8'h00};
    tb_ = '{8'h05, 8'h80, 8'h80, 8'hFF};
    te  = '{16'hFFF1, 16'h4000, 16'hC080, 16'h0000};
    for (int i = 0; i < 4; i++) begin
      send(ta[i], tb_[i]);
      tick; tick; tick;
      wait_valid(100, n);
      total++; if ({out_valid, out_prod, out_err} !== {1'b1, te[i], 1'b0}) begin bad++; $display("FAIL signed_%0d got=%b_%h_%b want=1_%h_0", i, out_valid, out_prod, out_err, te[i]); end
      tick;
    end
  endtask

  task test_backpressure;
    int n;
    int stable_bad;
    out_ready = 1'b0;
    send(8'hFE, 8'd9);
    tick; tick; tick;
    wait_valid(100, n);
    in_a = 8'd4; in_b = 8'd6; in_valid = 1'b1;
    stable_bad = 0;
    for (int i = 0; i < 10; i++) begin
      total++;
      if ({out_valid, out_prod, out_err, in_ready, core_rst} !== {1'b1, 16'hFFEE, 1'b0, 1'b0, 1'b1}) begin
        bad++; stable_bad++;
        $display("FAIL bp_hold_%0d got=%b_%h_%b_%b_%b want=1_ffee_0_0_1", i, out_valid, out_prod, out_err, in_ready, core_rst);
      end
      tick;
    end
    out_ready = 1'b1;
    tick;
    total++; if ({out_valid, in_ready, core_rst} !== 3'b010) begin bad++; $display("FAIL bp_release got=%b want=010", {out_valid, in_ready, core_rst}); end
    tick;
    total++; if ({in_ready, core_rst} !== 2'b00) begin bad++; $display("FAIL bp_accept got=%b want=00", {in_ready, core_rst}); end
    in_valid = 1'b0;
    tick; tick; tick;
    wait_valid(100, n);
    total++; if ({n, out_prod, out_err} !== {32'd21, 16'h0018, 1'b0}) begin bad++; $display("FAIL bp_next got=%0d_%h_%b want=21_0018_0", n, out_prod, out_err); end
    tick;
  endtask

  task test_timeout;
    int n;
    int dl [3];
    logic [16:0] te [3];
    dl = '{1000, 62, 63};
    te = '{{16'h0000, 1'b1}, {16'h0019, 1'b0}, {16'h0000, 1'b1}};
    for (int i = 0; i < 3; i++) begin
      stop_dly = dl[i];
      send(8'd5, 8'd5);
      tick; tick; tick;
      wait_valid(200, n);
      total++; if (n !== 63) begin bad++; $display("FAIL timeout_lat_%0d got=%0d want=63", i, n); end
      total++; if ({out_valid, out_prod, out_err} !== {1'b1, te[i]}) begin bad++; $display("FAIL timeout_res_%0d got=%b_%h_%b want=1_%h_%b", i, out_valid, out_prod, out_err, te[i][16:1], te[i][0]); end
      tick;
    end
    stop_dly = 20;
  endtask

  task test_reset_mid;
    int n;
    int seen;
    send(8'd1, 8'd2);
    tick; tick; tick;
    repeat (5) tick;
    rst = 1'b0;
    tick;
    total++; if ({in_ready, core_rst, out_valid, core_start} !== 4'b1000) begin bad++; $display("FAIL rmid_abort got=%b want=1000", {in_ready, core_rst, out_valid, core_start}); end
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin tick; if (out_valid) seen++; end
    total++; if (seen !== 0) begin bad++; $display("FAIL rmid_noresult got=%0d want=0", seen); end
    send(8'd7, 8'hF7);
    tick; tick; tick;
    wait_valid(100, n);
    total++; if ({out_valid, out_prod, out_err} !== {1'b1, 16'hFFC1, 1'b0}) begin bad++; $display("FAIL rmid_next got=%b_%h_%b want=1_ffc1_0", out_valid, out_prod, out_err); end
    tick;
  endtask

  task test_back_to_back;
    logic [7:0]  ta [4];
    logic [7:0]  tb_ [4];
    logic [15:0] te [4];
    int idx_in, idx_out, starts;
    logic acc, prev_rst;
    ta  = '{8'd10, 8'hFF, 8'hCE, 8'd100};
    tb_ = '{8'd10, 8'hFF, 8'h03, 8'h9C};
    te  = '{16'h0064, 16'h0001, 16'hFF6A, 16'hD8F0};
    out_ready = 1'b1;
    idx_in = 0; idx_out = 0; starts = 0;
    prev_rst = core_rst;
    in_a = ta[0]; in_b = tb_[0]; in_valid = 1'b1;
    for (int c = 0; c < 400 && idx_out < 4; c++) begin
      acc = in_valid && in_ready;
      tick;
      if (acc) begin
        idx_in++;
        if (idx_in < 4) begin in_a = ta[idx_in]; in_b = tb_[idx_in]; end
        else in_valid = 1'b0;
      end
      if (core_start === 1'b1) begin
        starts++;
        total++; if (prev_rst !== 1'b0) begin bad++; $display("FAIL b2b_crst_%0d got=%b want=0", starts, prev_rst); end
      end
      if (out_valid === 1'b1) begin
        total++; if ({out_prod, out_err} !== {te[idx_out], 1'b0}) begin bad++; $display("FAIL b2b_res_%0d got=%h_%b want=%h_0", idx_out, out_prod, out_err, te[idx_out]); end
        idx_out++;
      end
      prev_rst = core_rst;
    end
    in_valid = 1'b0;
    total++; if (idx_out !== 4) begin bad++; $display("FAIL b2b_count got=%0d want=4", idx_out); end
    total++; if (starts !== 4) begin bad++; $display("FAIL b2b_starts got=%0d want=4", starts); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_signed;
    test_backpressure;
    test_timeout;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
